// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
//
// Per-frame sequencer for the single framebuffer pixel-write port. On an
// accepted frame_tick it optionally runs the clear engine, then each object
// drawer in index order. Each step uses a level start / done handshake. The
// active client's pixel is muxed onto px_*, and off-screen pixels are dropped.
// Frame ticks that arrive while a frame is in progress are counted as overruns.
// A per-step watchdog skips a drawer that never signals done.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   frame_tick          one-cycle pulse marking the start of a frame
//   clear_en            sampled with an accepted frame_tick: clear this frame
//   clr_start/clr_done  clear engine handshake
//   clr_x, clr_y        clear engine pixel coordinates
//   obj_start/obj_done  drawer handshake, one bit per drawer (start is one-hot)
//   obj_x, obj_y        packed drawer coordinates, drawer i at [i*COORD_W +: COORD_W]
//   obj_color           drawer pixel colour, one bit per drawer
//   px_x, px_y          framebuffer write coordinates
//   px_color, px_we     framebuffer write colour and write enable
//   busy                frame in progress
//   overrun_cnt         saturating count of frame_ticks rejected while busy
//   timeout_err         sticky flag: the watchdog has fired at least once
// -----------------------------------------------------------------------------
module frame_scheduler #(
    parameter int NUM_OBJ = 3,
    parameter int COORD_W = 11,
    parameter int X_MAX   = 639,
    parameter int Y_MAX   = 479,
    parameter int TIMEOUT = 1048576
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_tick,
    input  logic                       clear_en,
    output logic                       clr_start,
    input  logic                       clr_done,
    input  logic [COORD_W-1:0]         clr_x,
    input  logic [COORD_W-1:0]         clr_y,
    output logic [NUM_OBJ-1:0]         obj_start,
    input  logic [NUM_OBJ-1:0]         obj_done,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_x,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_y,
    input  logic [NUM_OBJ-1:0]         obj_color,
    output logic [COORD_W-1:0]         px_x,
    output logic [COORD_W-1:0]         px_y,
    output logic                       px_color,
    output logic                       px_we,
    output logic                       busy,
    output logic [7:0]                 overrun_cnt,
    output logic                       timeout_err
);

    localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    // The watchdog never counts past TIMEOUT-1, so log2 bits are enough.
    localparam int WD_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DRAW
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [WD_W-1:0]    wdog;
    logic               active_done;
    logic               step_done;
    logic               wd_fire;
    logic               advance;
    logic               clr_start_nxt;
    logic [NUM_OBJ-1:0] obj_start_nxt;

    // Done bit of the currently selected drawer; other drawers are ignored.
    always_comb begin
        active_done = 1'b0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (idx == IDX_W'(i)) active_done = obj_done[i];
        end
    end

    // Next-state logic. Start outputs are computed from the next state so
    // that they are registered and change on the same edge as the state.
    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        step_done = 1'b0;

        case (state)
            S_CLEAR: step_done = clr_done;
            S_DRAW:  step_done = active_done;
            default: step_done = 1'b0;
        endcase

        // Watchdog fires only in the cycle the step would otherwise overstay.
        wd_fire = (state != S_IDLE) && !step_done && (wdog == WD_W'(TIMEOUT - 1));
        advance = step_done || wd_fire;

        case (state)
            S_IDLE: begin
                if (frame_tick) begin
                    idx_nxt   = '0;
                    state_nxt = clear_en ? S_CLEAR : S_DRAW;
                end
            end
            S_CLEAR: begin
                if (advance) begin
                    idx_nxt   = '0;
                    state_nxt = S_DRAW;
                end
            end
            S_DRAW: begin
                if (advance) begin
                    if (idx == IDX_W'(NUM_OBJ - 1)) begin
                        idx_nxt   = '0;
                        state_nxt = S_IDLE;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                idx_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase

        clr_start_nxt = (state_nxt == S_CLEAR);
        for (int i = 0; i < NUM_OBJ; i++) begin
            obj_start_nxt[i] = (state_nxt == S_DRAW) && (idx_nxt == IDX_W'(i));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            wdog        <= '0;
            clr_start   <= 1'b0;
            obj_start   <= '0;
            overrun_cnt <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            clr_start <= clr_start_nxt;
            obj_start <= obj_start_nxt;

            // Restart on every step entry (including leaving IDLE).
            if (state == S_IDLE || advance) wdog <= '0;
            else                             wdog <= wdog + WD_W'(1);

            if (frame_tick && state != S_IDLE && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;

            if (wd_fire) timeout_err <= 1'b1;
        end
    end

    assign busy = (state != S_IDLE);

    // Pixel mux, combinational from state and idx.
    always_comb begin
        px_x     = '0;
        px_y     = '0;
        px_color = 1'b0;
        case (state)
            S_CLEAR: begin
                px_x = clr_x;
                px_y = clr_y;
            end
            S_DRAW: begin
                for (int i = 0; i < NUM_OBJ; i++) begin
                    if (idx == IDX_W'(i)) begin
                        px_x     = obj_x[i*COORD_W +: COORD_W];
                        px_y     = obj_y[i*COORD_W +: COORD_W];
                        px_color = obj_color[i];
                    end
                end
            end
            default: ;
        endcase
    end

    // Off-screen pixels are dropped rather than clamped.
    assign px_we = (state != S_IDLE)
                && (px_x <= COORD_W'(X_MAX))
                && (px_y <= COORD_W'(Y_MAX));

endmodule
